// File: rtl/perf_event_shaper.sv
// perf_event_shaper
//   Turns multi-occurrence per-cycle event counts into at most one registered
//   pulse per lane per cycle. Occurrences that cannot be pulsed right away are
//   held in a per-lane saturating backlog counter. When a backlog saturates,
//   the excess is dropped and a sticky lost flag is set for that lane.
//
// Ports
//   clk, rst_n    clock; asynchronous active-low reset
//   evt_count_i   packed per-lane occurrence counts, lane k at [k*CNT_W +: CNT_W]
//   inhibit_i     per-lane inhibit: count dropped, backlog frozen, no pulse
//   flush_i       clears every backlog and suppresses the next pulses
//   lost_clr_i    clears the sticky lost flags (a same-cycle overflow wins)
//   priv_mode_i   privilege mode, delayed one cycle to priv_mode_o
//   evt_pulse_o   registered per-lane event strobes
//   priv_mode_o   privilege mode aligned with evt_pulse_o
//   lost_o        sticky per-lane overflow flags
//   busy_o        registered OR of (backlog != 0) across all lanes

// Per-lane backlog and pulse logic.
module pes_lane #(
  parameter int CNT_W     = 2,
  parameter int BACKLOG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_inhibit,
  input  logic             i_flush,
  input  logic             i_lost_clr,
  output logic             o_pulse,
  output logic             o_lost,
  output logic             o_bl_nz_nxt
);
  localparam logic [BACKLOG_W:0] BL_MAX = {1'b0, {BACKLOG_W{1'b1}}};

  logic [BACKLOG_W-1:0] r_bl;
  logic                 r_pulse;
  logic                 r_lost;

  logic [BACKLOG_W:0]   w_total;
  logic [BACKLOG_W:0]   w_rem;
  logic                 w_any;
  logic                 w_ovf;
  logic [BACKLOG_W-1:0] w_bl_nxt;
  logic                 w_pulse_nxt;
  logic                 w_set_lost;

  always_comb begin
    // One extra bit so backlog + count never wraps before the clamp.
    w_total     = {1'b0, r_bl} + {{(BACKLOG_W+1-CNT_W){1'b0}}, i_cnt};
    w_any       = (w_total != '0);
    w_rem       = w_total - {{BACKLOG_W{1'b0}}, w_any};
    w_ovf       = (w_rem > BL_MAX);
    w_bl_nxt    = r_bl;
    w_pulse_nxt = 1'b0;
    w_set_lost  = 1'b0;
    if (i_flush) begin
      w_bl_nxt = '0;
    end else if (!i_inhibit) begin
      w_pulse_nxt = w_any;
      w_bl_nxt    = w_ovf ? BL_MAX[BACKLOG_W-1:0] : w_rem[BACKLOG_W-1:0];
      w_set_lost  = w_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bl    <= '0;
      r_pulse <= 1'b0;
      r_lost  <= 1'b0;
    end else begin
      r_bl    <= w_bl_nxt;
      r_pulse <= w_pulse_nxt;
      r_lost  <= w_set_lost | (r_lost & ~i_lost_clr);
    end
  end

  assign o_pulse     = r_pulse;
  assign o_lost      = r_lost;
  assign o_bl_nz_nxt = (w_bl_nxt != '0);
endmodule

module perf_event_shaper #(
  parameter int NUM_EVENTS = 13,
  parameter int CNT_W      = 2,
  parameter int BACKLOG_W  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_EVENTS*CNT_W-1:0] evt_count_i,
  input  logic [NUM_EVENTS-1:0]       inhibit_i,
  input  logic                        flush_i,
  input  logic                        lost_clr_i,
  input  logic [1:0]                  priv_mode_i,
  output logic [NUM_EVENTS-1:0]       evt_pulse_o,
  output logic [1:0]                  priv_mode_o,
  output logic [NUM_EVENTS-1:0]       lost_o,
  output logic                        busy_o
);
  logic [NUM_EVENTS-1:0] w_bl_nz_nxt;
  logic [1:0]            r_priv;
  logic                  r_busy;

  for (genvar k = 0; k < NUM_EVENTS; k++) begin : g_lane
    pes_lane #(
      .CNT_W     (CNT_W),
      .BACKLOG_W (BACKLOG_W)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_cnt       (evt_count_i[k*CNT_W +: CNT_W]),
      .i_inhibit   (inhibit_i[k]),
      .i_flush     (flush_i),
      .i_lost_clr  (lost_clr_i),
      .o_pulse     (evt_pulse_o[k]),
      .o_lost      (lost_o[k]),
      .o_bl_nz_nxt (w_bl_nz_nxt[k])
    );
  end

  // busy is taken from the next-backlog values so it lines up with the
  // pulses registered on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_priv <= 2'b11;
      r_busy <= 1'b0;
    end else begin
      r_priv <= priv_mode_i;
      r_busy <= |w_bl_nz_nxt;
    end
  end

  assign priv_mode_o = r_priv;
  assign busy_o      = r_busy;
endmodule

// File: doc/perf_event_shaper.md
# perf_event_shaper

Upstream stage of the performance-counter CSR block. It collects raw per-cycle event counts from the pipeline, cache and TLB, where a lane may report several occurrences in one cycle. It buffers excess occurrences in per-lane backlog counters and emits at most one registered pulse per lane per cycle. The registered pulses drive the counter block's single-bit event inputs, so multi-issue bursts are not lost.

## Interface
- NUM_EVENTS, 13, number of event lanes; lane k feeds counter event select k+1 (lane 0 = cycles ... lane 12 = interrupts)
- CNT_W, 2, width of each lane's per-cycle occurrence count
- BACKLOG_W, 4, width of each lane's backlog counter; BL_MAX = 2^BACKLOG_W-1

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- evt_count_i  in  NUM_EVENTS*CNT_W  packed occurrence counts; lane k at bits [k*CNT_W +: CNT_W]
- inhibit_i  in  NUM_EVENTS  per-lane inhibit (mcountinhibit-style)
- flush_i  in  1  synchronous clear of all backlogs
- lost_clr_i  in  1  clears all sticky lost flags
- priv_mode_i  in  2  current privilege mode
- evt_pulse_o  out  NUM_EVENTS  registered event strobes to the counter block
- priv_mode_o  out  2  priv_mode_i delayed to align with evt_pulse_o
- lost_o  out  NUM_EVENTS  sticky: backlog saturated and occurrences were dropped
- busy_o  out  1  OR of (backlog != 0) over all lanes, registered

## Operation
- Per lane, per cycle t: total = backlog + count, computed at BACKLOG_W+1 bits with no wrap.
  - pulse = (total != 0).
  - backlog' = min(total - pulse, BL_MAX).
- Overflow: if total - pulse > BL_MAX, set lost[k]; the excess is discarded and the backlog sticks at BL_MAX.
- Inhibit (inhibit_i[k]=1):
  - count[k] is discarded.
  - pulse = 0.
  - backlog[k] holds its value.
  - lost[k] is not set.
  - Draining resumes the cycle after inhibit falls.
- Flush (flush_i=1):
  - All backlogs become 0.
  - All pulses for the next cycle are 0.
  - That cycle's counts are discarded.
  - lost_o is unaffected.
  - Flush has priority over inhibit and counts.
- lost_clr_i clears all lost bits. If a lane overflows in the same cycle, set wins for that lane.
- Lanes are fully independent. There is no arbitration between lanes.
- priv_mode_o is a plain 1-cycle register stage, so the consumer's mode filter sees the mode in which the event was reported.
  - Exception: occurrences drained from the backlog carry the mode of their drain cycle.

## Timing
- Every output is registered.
- Latency from evt_count_i to evt_pulse_o is 1 cycle when the backlog is empty.
- Reset values: evt_pulse_o=0, priv_mode_o=2'b11, lost_o=0, busy_o=0; all backlogs 0.
- Asserting rst_n low mid-burst clears all state asynchronously. No pulses occur after reset is released until new counts arrive.
- busy_o reflects the backlog value registered in the same edge as evt_pulse_o. busy_o=0 and evt_pulse_o=1 can coexist on the final drain cycle.
- Sustained count=1 per cycle gives a continuous pulse train with the backlog stable at 0.
- Sustained count >= 2 grows the backlog by (count-1) per cycle.

## Test plan
- Single event: lane 1 count=1 in cycle 5 only -> evt_pulse_o[1]=1 in cycle 6 only; busy_o stays 0.
- Burst: lane 3 count=3 in cycle t only -> evt_pulse_o[3]=1 for cycles t+1..t+3; busy_o=1 for t+1..t+2, 0 at t+3.
- Saturation (BACKLOG_W=4): lane 1 count=3 for 10 cycles, then 0.
  - Backlog reaches 15 and lost_o[1]=1.
  - Pulses are continuous for 10 cycles, then exactly 15 more pulses follow.
  - lost_clr_i then clears lost_o[1].
- Inhibit: lane 2 count=2 in cycle t, inhibit_i[2]=1 for cycles t+1..t+4.
  - Pulse in cycle t+1.
  - No pulse for t+2..t+5; backlog holds at 1.
  - Single pulse in cycle t+6.
- Flush mid-drain: lane 5 backlog=8 and flush_i=1 with count=3 in the same cycle -> no lane-5 pulses on following cycles, busy_o=0, lost_o unchanged.
- Reset mid-operation: several lanes with backlog > 0, then rst_n asserted asynchronously between clock edges.
  - All outputs go to reset values immediately.
  - After release, idle inputs produce no pulses.
  - priv_mode_o=2'b11 until the first clock after release.
